// File: rtl/rv3n_gsr_wb_sched.sv
// rtl/rv3n_gsr_wb_sched.sv - write-back scheduler merging lane writes and queued load returns
module rv3n_gsr_wb_sched #(
  parameter int PNUM       = 2,
  parameter int XLEN       = 32,
  parameter int RGBIT      = 5,
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PNUM*RGBIT-1:0] ex2wb_order,
  input  logic [PNUM*XLEN-1:0]  ex2wb_data,
  input  logic                  mem2wb_valid,
  input  logic [RGBIT-1:0]      mem2wb_rd,
  input  logic [XLEN-1:0]       mem2wb_data,
  output logic                  mem2wb_ready,
  input  logic                  id2wb_ld_set,
  input  logic [RGBIT-1:0]      id2wb_ld_rd,
  output logic [31:0]           wb2id_busy,
  output logic                  wb2ex_hold,
  output logic [PNUM*RGBIT-1:0] wb2gsr_order,
  output logic [PNUM*XLEN-1:0]  wb2gsr_data
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [0:0] {S_NORMAL, S_DRAIN} state_t;

  logic [RGBIT-1:0]      q_rd   [LQ_DEPTH];
  logic [XLEN-1:0]       q_data [LQ_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic                  push;
  logic [CW-1:0]         pops;
  logic [PNUM*RGBIT-1:0] nxt_order;
  logic [PNUM*XLEN-1:0]  nxt_data;
  logic [PNUM-1:0]       nxt_ld, out_ld;
  logic [31:0]           busy_nxt;
  state_t                state, state_nxt;
  logic [SW-1:0]         cnt, cnt_nxt;
  logic                  stalled;

  // Queue can accept only while the registered occupancy leaves room; rd==0 returns are discarded.
  assign mem2wb_ready = (count < CW'(LQ_DEPTH));
  assign push         = mem2wb_valid && mem2wb_ready && (mem2wb_rd != '0);
  assign wb2ex_hold   = (state == S_DRAIN);

  // Fill free slots with queue heads in age order; the first head colliding with a lane rd blocks the rest.
  always_comb begin
    logic          stop;
    logic          hit;
    logic [PW-1:0] idx;
    nxt_order = ex2wb_order;
    nxt_data  = ex2wb_data;
    nxt_ld    = '0;
    pops      = '0;
    stop      = 1'b0;
    hit       = 1'b0;
    idx       = '0;
    for (int j = 0; j < PNUM; j++) begin
      if ((ex2wb_order[j*RGBIT +: RGBIT] == '0) && !stop && (pops < count)) begin
        idx = rd_ptr + PW'(pops);
        hit = 1'b0;
        for (int k = 0; k < PNUM; k++) begin
          if ((ex2wb_order[k*RGBIT +: RGBIT] != '0) &&
              (ex2wb_order[k*RGBIT +: RGBIT] == q_rd[idx])) begin
            hit = 1'b1;
          end
        end
        if (hit) begin
          stop = 1'b1;
        end else begin
          nxt_order[j*RGBIT +: RGBIT] = q_rd[idx];
          nxt_data[j*XLEN +: XLEN]    = q_data[idx];
          nxt_ld[j]                   = 1'b1;
          pops                        = pops + CW'(1);
        end
      end
    end
  end

  // Load-return storage; contents are qualified by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= mem2wb_rd;
      q_data[wr_ptr] <= mem2wb_data;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr + PW'(pops);
      count  <= count + CW'(push) - pops;
    end
  end

  // Register-file write ports, plus a flag per port marking which writes came from the load queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb2gsr_order <= '0;
      wb2gsr_data  <= '0;
      out_ld       <= '0;
    end else begin
      wb2gsr_order <= nxt_order;
      wb2gsr_data  <= nxt_data;
      out_ld       <= nxt_ld;
    end
  end

  // Pending-load flags clear as the load write is latched by the register file; a new issue wins.
  always_comb begin
    busy_nxt = wb2id_busy;
    for (int p = 0; p < PNUM; p++) begin
      if (out_ld[p]) busy_nxt[wb2gsr_order[p*RGBIT +: RGBIT]] = 1'b0;
    end
    if (id2wb_ld_set && (id2wb_ld_rd != '0)) busy_nxt[id2wb_ld_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) wb2id_busy <= '0;
    else     wb2id_busy <= busy_nxt;
  end

  // Starvation FSM next state: count stalled cycles, then force lanes to hold until the queue empties.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stalled   = (count != '0) && (pops == '0);
    case (state)
      S_NORMAL: begin
        if (stalled) begin
          if (cnt == SW'(STARVE_MAX - 1)) begin
            state_nxt = S_DRAIN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + SW'(1);
          end
        end else begin
          cnt_nxt = '0;
        end
      end
      S_DRAIN: begin
        cnt_nxt = '0;
        if (count == '0) state_nxt = S_NORMAL;
      end
      default: begin
        state_nxt = S_NORMAL;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Starvation FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_NORMAL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule
